// File: rtl/project_period_counter_master.sv
// PWM master timebase: reference period counter, prescaled sync and per-slave phase-load strobes.
// Optional `PWM_MASTER_SYNC_ON_PEAK_EN: the UP_DOWN peak is also a period event.
module project_period_counter_master #(
  parameter int NUM_SLAVES = 4,
  parameter int DIV_W      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [15:0]           i_period,
  input  logic                  i_period_wr,
  input  logic [DIV_W-1:0]      i_sync_div,
  input  logic [NUM_SLAVES-1:0] i_sync_mask,
  input  logic                  i_sw_sync,
  output logic                  o_sync,
  output logic [NUM_SLAVES-1:0] o_sync_slave,
  output logic                  o_period_event,
  output logic [15:0]           o_counter,
  output logic [15:0]           o_period_active,
  output logic                  o_dir
);

  typedef enum logic [1:0] {
    M_OFF  = 2'b00,
    M_UP   = 2'b01,
    M_DOWN = 2'b10,
    M_UPDN = 2'b11
  } mode_e;

  mode_e            mode;
  logic [15:0]      cnt_q, per_q, shadow_q;
  logic             dir_q;
  logic [DIV_W-1:0] div_q;

  logic [15:0]      cnt_n;
  logic             dir_n;
  logic             evt;
  logic             sync_hit;
  logic [15:0]      shadow_eff;

  assign mode = mode_e'(i_mode);

  // A write coincident with an event or OFF-load goes straight to the active period.
  assign shadow_eff = i_period_wr ? i_period : shadow_q;

  always_comb begin
    cnt_n = cnt_q;
    dir_n = 1'b0;
    evt   = 1'b0;
    case (mode)
      M_UP: begin
        if (cnt_q >= per_q) begin
          cnt_n = 16'd0;
          evt   = 1'b1;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      M_DOWN: begin
        if (cnt_q == 16'd0) begin
          cnt_n = shadow_eff;
          evt   = 1'b1;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      M_UPDN: begin
        dir_n = dir_q;
        if (per_q == 16'd0) begin
          cnt_n = 16'd0;
          dir_n = 1'b0;
          evt   = 1'b1;
        end else if (!dir_q) begin
          if (cnt_q >= per_q) begin
            cnt_n = per_q - 16'd1;
            dir_n = 1'b1;
          end else begin
            cnt_n = cnt_q + 16'd1;
`ifdef PWM_MASTER_SYNC_ON_PEAK_EN
            evt   = (cnt_n == per_q);
`endif
          end
        end else begin
          if (cnt_q == 16'd0) begin
            cnt_n = 16'd1;
            dir_n = 1'b0;
          end else begin
            cnt_n = cnt_q - 16'd1;
            evt   = (cnt_q == 16'd1);
          end
        end
      end
      default: ;
    endcase
  end

  assign sync_hit = evt && (div_q == i_sync_div);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q          <= '0;
      per_q          <= '0;
      shadow_q       <= '0;
      dir_q          <= 1'b0;
      div_q          <= '0;
      o_sync         <= 1'b0;
      o_sync_slave   <= '0;
      o_period_event <= 1'b0;
    end else begin
      if (i_period_wr) shadow_q <= i_period;
      if (!i_en) begin
        o_sync         <= 1'b0;
        o_sync_slave   <= '0;
        o_period_event <= 1'b0;
      end else if (i_sw_sync) begin
        cnt_q          <= '0;
        dir_q          <= 1'b0;
        div_q          <= '0;
        per_q          <= shadow_eff;
        o_sync         <= 1'b1;
        o_sync_slave   <= i_sync_mask;
        o_period_event <= 1'b0;
      end else begin
        cnt_q <= cnt_n;
        dir_q <= dir_n;
        if (evt || mode == M_OFF) per_q <= shadow_eff;
        // Equality test is live, so an over-range count wraps through the full width.
        if (evt) div_q <= sync_hit ? '0 : div_q + DIV_W'(1);
        o_sync         <= sync_hit;
        o_sync_slave   <= sync_hit ? i_sync_mask : '0;
        o_period_event <= evt;
      end
    end
  end

  assign o_counter       = cnt_q;
  assign o_period_active = per_q;
  assign o_dir           = dir_q;

endmodule

// File: tb/tb_project_period_counter_master.sv
// Directed bench for project_period_counter_master; expected values are hand-derived per scenario.
module tb_project_period_counter_master;
  localparam int NS = 4;
  localparam int DW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_en;
  logic [1:0]    i_mode;
  logic [15:0]   i_period;
  logic          i_period_wr;
  logic [DW-1:0] i_sync_div;
  logic [NS-1:0] i_sync_mask;
  logic          i_sw_sync;
  logic          o_sync;
  logic [NS-1:0] o_sync_slave;
  logic          o_period_event;
  logic [15:0]   o_counter;
  logic [15:0]   o_period_active;
  logic          o_dir;

  int nchk = 0;
  int nerr = 0;

  project_period_counter_master #(.NUM_SLAVES(NS), .DIV_W(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_mode(i_mode),
    .i_period(i_period), .i_period_wr(i_period_wr), .i_sync_div(i_sync_div),
    .i_sync_mask(i_sync_mask), .i_sw_sync(i_sw_sync), .o_sync(o_sync),
    .o_sync_slave(o_sync_slave), .o_period_event(o_period_event),
    .o_counter(o_counter), .o_period_active(o_period_active), .o_dir(o_dir)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_en = 1'b1; i_mode = 2'b00; i_period = '0; i_period_wr = 1'b0;
    i_sync_div = '0; i_sync_mask = '0; i_sw_sync = 1'b0;
    tick();
    i_reset = 1'b0;
  endtask

  // Load a period while OFF so counting starts from 0 with it already active.
  task automatic load_off(input logic [15:0] p);
    i_mode = 2'b00; i_period = p; i_period_wr = 1'b1;
    tick();
    i_period_wr = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_en = 1'b1; i_mode = 2'b01; i_period = '0; i_period_wr = 1'b0;
    i_sync_div = '0; i_sync_mask = '1; i_sw_sync = 1'b0;
    #2;
    nchk++; if (o_counter !== 16'd0) begin nerr++; $display("FAIL reset_counter got %0d want 0", o_counter); end
    nchk++; if (o_period_active !== 16'd0) begin nerr++; $display("FAIL reset_period got %0d want 0", o_period_active); end
    nchk++; if ({o_sync, o_sync_slave, o_period_event, o_dir} !== 7'd0) begin
      nerr++; $display("FAIL reset_strobes got %b%b%b%b want 0", o_sync, o_sync_slave, o_period_event, o_dir); end
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_up();
    logic [15:0] ec;
    do_reset();
    load_off(16'd3);
    nchk++; if (o_period_active !== 16'd3) begin nerr++; $display("FAIL up_load got %0d want 3", o_period_active); end
    i_mode = 2'b01; i_sync_div = '0; i_sync_mask = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      tick();
      ec = 16'((k + 1) % 4);
      nchk++; if (o_counter !== ec) begin nerr++; $display("FAIL up_cnt k=%0d got %0d want %0d", k, o_counter, ec); end
      nchk++; if (o_period_event !== (ec == 0) || o_sync !== (ec == 0)) begin
        nerr++; $display("FAIL up_evt k=%0d got ev=%b sync=%b want %b", k, o_period_event, o_sync, ec == 0); end
      nchk++; if (o_sync_slave !== ((ec == 0) ? 4'b0101 : 4'b0000)) begin
        nerr++; $display("FAIL up_slave k=%0d got %b", k, o_sync_slave); end
    end
  endtask

  task automatic test_down();
    logic [15:0] ec;
    logic ev, sy;
    do_reset();
    load_off(16'd5);
    i_mode = 2'b10; i_sync_div = 4'd2; i_sync_mask = 4'b1111;
    for (int k = 0; k < 19; k++) begin
      tick();
      ec = 16'(5 - (k % 6));
      ev = (k % 6 == 0);
      sy = ev && ((k / 6) % 3 == 2);
      nchk++; if (o_counter !== ec) begin nerr++; $display("FAIL down_cnt k=%0d got %0d want %0d", k, o_counter, ec); end
      nchk++; if (o_period_event !== ev || o_sync !== sy) begin
        nerr++; $display("FAIL down_evt k=%0d got ev=%b sync=%b want ev=%b sync=%b", k, o_period_event, o_sync, ev, sy); end
    end
  endtask

  task automatic test_updown();
    logic [15:0] ecs [10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    logic        eds [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic        evs [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
`ifdef PWM_MASTER_SYNC_ON_PEAK_EN
    evs[3] = 1'b1;
`endif
    do_reset();
    load_off(16'd4);
    i_mode = 2'b11; i_sync_div = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      nchk++; if (o_counter !== ecs[k] || o_dir !== eds[k]) begin
        nerr++; $display("FAIL updn_cnt k=%0d got %0d/%b want %0d/%b", k, o_counter, o_dir, ecs[k], eds[k]); end
      nchk++; if (o_period_event !== evs[k] || o_sync !== evs[k]) begin
        nerr++; $display("FAIL updn_evt k=%0d got ev=%b sync=%b want %b", k, o_period_event, o_sync, evs[k]); end
    end
    // Leaving UP_DOWN while going down clears dir without resetting the count.
    for (int k = 0; k < 4; k++) tick();
    nchk++; if (o_dir !== 1'b1) begin nerr++; $display("FAIL updn_dir1 got %b want 1", o_dir); end
    i_mode = 2'b01;
    tick();
    nchk++; if (o_dir !== 1'b0 || o_counter !== 16'd3) begin
      nerr++; $display("FAIL updn_leave got %0d/%b want 3/0", o_counter, o_dir); end
  endtask

  task automatic test_period_update();
    do_reset();
    load_off(16'd10);
    i_mode = 2'b01;
    for (int k = 1; k <= 3; k++) tick();
    i_period = 16'd6; i_period_wr = 1'b1;
    tick();
    i_period_wr = 1'b0;
    nchk++; if (o_counter !== 16'd4 || o_period_active !== 16'd10) begin
      nerr++; $display("FAIL pu_hold got %0d/%0d want 4/10", o_counter, o_period_active); end
    for (int k = 5; k <= 10; k++) begin
      tick();
      nchk++; if (o_counter !== 16'(k)) begin nerr++; $display("FAIL pu_cnt got %0d want %0d", o_counter, k); end
    end
    tick();
    nchk++; if (o_counter !== 16'd0 || o_period_event !== 1'b1 || o_period_active !== 16'd6) begin
      nerr++; $display("FAIL pu_wrap got %0d/%b/%0d want 0/1/6", o_counter, o_period_event, o_period_active); end
    for (int k = 1; k <= 6; k++) tick();
    nchk++; if (o_counter !== 16'd6) begin nerr++; $display("FAIL pu_top got %0d want 6", o_counter); end
    i_period = 16'd2; i_period_wr = 1'b1;
    tick();
    i_period_wr = 1'b0;
    nchk++; if (o_counter !== 16'd0 || o_period_event !== 1'b1 || o_period_active !== 16'd2) begin
      nerr++; $display("FAIL pu_wt got %0d/%b/%0d want 0/1/2", o_counter, o_period_event, o_period_active); end
    tick(); tick(); tick();
    nchk++; if (o_counter !== 16'd0 || o_period_event !== 1'b1) begin
      nerr++; $display("FAIL pu_new got %0d/%b want 0/1", o_counter, o_period_event); end
  endtask

  task automatic test_sw_sync();
    logic [15:0] ec;
    do_reset();
    load_off(16'd9);
    i_mode = 2'b01; i_sync_div = 4'd3; i_sync_mask = 4'b1111;
    for (int k = 0; k < 17; k++) tick();
    nchk++; if (o_counter !== 16'd7) begin nerr++; $display("FAIL sw_pre got %0d want 7", o_counter); end
    i_period = 16'd1; i_period_wr = 1'b1; i_sw_sync = 1'b1;
    tick();
    i_period_wr = 1'b0; i_sw_sync = 1'b0;
    nchk++; if (o_counter !== 16'd0 || o_sync !== 1'b1 || o_period_event !== 1'b0) begin
      nerr++; $display("FAIL sw_hit got %0d/%b/%b want 0/1/0", o_counter, o_sync, o_period_event); end
    nchk++; if (o_sync_slave !== 4'b1111 || o_period_active !== 16'd1) begin
      nerr++; $display("FAIL sw_slave got %b/%0d want 1111/1", o_sync_slave, o_period_active); end
    // Divider restarted at 0: with div=3 the 4th following event is the first sync.
    for (int j = 1; j <= 9; j++) begin
      tick();
      ec = 16'(j % 2);
      nchk++; if (o_counter !== ec || o_period_event !== (ec == 0) || o_sync !== (j == 8)) begin
        nerr++; $display("FAIL sw_after j=%0d got %0d/%b/%b want %0d/%b/%b", j, o_counter, o_period_event, o_sync, ec, ec == 0, j == 8); end
    end
    i_en = 1'b0; i_sw_sync = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin i_period = 16'd3; i_period_wr = 1'b1; end
      else i_period_wr = 1'b0;
      tick();
      nchk++; if (o_counter !== 16'd1 || o_period_event !== 1'b0 || o_sync !== 1'b0 || o_sync_slave !== 4'd0) begin
        nerr++; $display("FAIL en_frozen k=%0d got %0d/%b/%b/%b", k, o_counter, o_period_event, o_sync, o_sync_slave); end
    end
    i_en = 1'b1; i_sw_sync = 1'b0; i_period_wr = 1'b0;
    tick();
    nchk++; if (o_counter !== 16'd0 || o_period_event !== 1'b1 || o_sync !== 1'b0 || o_period_active !== 16'd3) begin
      nerr++; $display("FAIL en_resume got %0d/%b/%b/%0d want 0/1/0/3", o_counter, o_period_event, o_sync, o_period_active); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_off(16'd10);
    i_mode = 2'b01; i_sync_div = '0; i_sync_mask = 4'b0011;
    for (int k = 0; k < 4; k++) tick();
    nchk++; if (o_counter !== 16'd4) begin nerr++; $display("FAIL rm_pre got %0d want 4", o_counter); end
    i_reset = 1'b1;
    #1;
    nchk++; if (o_counter !== 16'd0 || o_period_active !== 16'd0 || o_period_event !== 1'b0 || o_sync !== 1'b0) begin
      nerr++; $display("FAIL rm_async got %0d/%0d/%b/%b want 0", o_counter, o_period_active, o_period_event, o_sync); end
    tick();
    i_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nchk++; if (o_counter !== 16'd0 || o_period_event !== 1'b1 || o_sync !== 1'b1 || o_sync_slave !== 4'b0011) begin
        nerr++; $display("FAIL rm_p0 k=%0d got %0d/%b/%b/%b", k, o_counter, o_period_event, o_sync, o_sync_slave); end
    end
    i_mode = 2'b00;
    tick();
    nchk++; if (o_period_event !== 1'b0 || o_sync !== 1'b0 || o_counter !== 16'd0) begin
      nerr++; $display("FAIL off_quiet got ev=%b sync=%b cnt=%0d", o_period_event, o_sync, o_counter); end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_updown();
    test_period_update();
    test_sw_sync();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
